// File: rtl/spi_master_if.sv
// Memory-mapped peripheral bus seen by the SPI master: one access per cycle
// while cs is high, with a registered ack and read-data return.
interface spi_master_if;
  logic        cs;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic [3:0]  bus_bytesel;
  logic        bus_ack;
  logic [31:0] bus_data;

  modport master (
    output cs, bus_addr, bus_wr_val, bus_bytesel,
    input  bus_ack, bus_data
  );

  modport slave (
    input  cs, bus_addr, bus_wr_val, bus_bytesel,
    output bus_ack, bus_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 byte master for SD cards in SPI mode: CTRL/STATUS/DATA registers
// on the peripheral bus, SCLK half-period of (div+1) clk cycles.
module spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd124
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state_reg,    state_next;
  logic [7:0]  div_reg,      div_next;
  logic        cs_n_reg,     cs_n_next;
  logic [7:0]  div_q_reg,    div_q_next;
  logic [7:0]  halfcnt_reg,  halfcnt_next;
  logic [2:0]  bitcnt_reg,   bitcnt_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  rx_byte_reg,  rx_byte_next;
  logic        overrun_reg,  overrun_next;
  logic        sclk_reg,     sclk_next;
  logic        mosi_reg,     mosi_next;
  logic        ack_reg,      ack_next;
  logic [31:0] rdata_reg,    rdata_next;

  logic       bus_wr, bus_rd, data_wr, busy, half_done;
  logic [3:0] addr;
  logic       unused_bits;

  assign addr        = bus.bus_addr[3:0];
  assign bus_wr      = bus.cs && (bus.bus_bytesel != 4'b0000);
  assign bus_rd      = bus.cs && (bus.bus_bytesel == 4'b0000);
  assign data_wr     = bus_wr && (addr == 4'h8);
  assign busy        = (state_reg != IDLE);
  assign half_done   = (halfcnt_reg == div_q_reg);
  assign unused_bits = ^{bus.bus_addr[31:4], bus.bus_wr_val[31:9]};

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    cs_n_next     = cs_n_reg;
    div_q_next    = div_q_reg;
    halfcnt_next  = halfcnt_reg;
    bitcnt_next   = bitcnt_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_byte_next  = rx_byte_reg;
    overrun_next  = overrun_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ack_next      = bus.cs;
    rdata_next    = 32'h0;

    if (bus_rd) begin
      case (addr)
        4'h0: rdata_next = {23'h0, cs_n_reg, div_reg};
        4'h4: begin
          rdata_next   = {30'h0, overrun_reg, busy};
          overrun_next = 1'b0;
        end
        4'h8:    rdata_next = {24'h0, rx_byte_reg};
        default: rdata_next = 32'h0;
      endcase
    end

    if (bus_wr && (addr == 4'h0)) begin
      div_next  = bus.bus_wr_val[7:0];
      cs_n_next = bus.bus_wr_val[8];
    end

    // Evaluated after the STATUS read so a simultaneous overrun set wins.
    case (state_reg)
      IDLE: begin
        if (data_wr) begin
          tx_shift_next = bus.bus_wr_val[7:0];
          mosi_next     = bus.bus_wr_val[7];
          bitcnt_next   = 3'd0;
          halfcnt_next  = 8'd0;
          div_q_next    = div_reg;
          state_next    = LOW;
        end
      end
      LOW: begin
        if (data_wr) overrun_next = 1'b1;
        if (half_done) begin
          sclk_next     = 1'b1;
          rx_shift_next = {rx_shift_reg[6:0], spi_miso};
          halfcnt_next  = 8'd0;
          state_next    = HIGH;
        end else begin
          halfcnt_next = halfcnt_reg + 8'd1;
        end
      end
      HIGH: begin
        if (data_wr) overrun_next = 1'b1;
        if (half_done) begin
          sclk_next    = 1'b0;
          halfcnt_next = 8'd0;
          if (bitcnt_reg == 3'd7) begin
            rx_byte_next = rx_shift_reg;
            mosi_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            bitcnt_next   = bitcnt_reg + 3'd1;
            mosi_next     = tx_shift_reg[6];
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            state_next    = LOW;
          end
        end else begin
          halfcnt_next = halfcnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_reg      <= DIV_RESET;
      cs_n_reg     <= 1'b1;
      div_q_reg    <= 8'h0;
      halfcnt_reg  <= 8'h0;
      bitcnt_reg   <= 3'd0;
      tx_shift_reg <= 8'h0;
      rx_shift_reg <= 8'h0;
      rx_byte_reg  <= 8'h0;
      overrun_reg  <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b1;
      ack_reg      <= 1'b0;
      rdata_reg    <= 32'h0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      cs_n_reg     <= cs_n_next;
      div_q_reg    <= div_q_next;
      halfcnt_reg  <= halfcnt_next;
      bitcnt_reg   <= bitcnt_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_byte_reg  <= rx_byte_next;
      overrun_reg  <= overrun_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ack_reg      <= ack_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign bus.bus_ack  = ack_reg;
  assign bus.bus_data = rdata_reg;
  assign spi_sclk     = sclk_reg;
  assign spi_mosi     = mosi_reg;
  assign spi_cs_n     = cs_n_reg;

endmodule

// File: doc/spi_master.md
# spi_master

Synthesizable SPI master (mode 0, MSB first) for SD-card access in SPI mode. It sits on the memory-mapped peripheral bus and drives the physical SCLK/MOSI/MISO/CS_N pins. It keeps the simulated SD model's data-register contract: write a byte at offset 0x8 to start a transfer, then read the received byte at offset 0x8. Control and status registers add clock division, chip-select control and busy/overrun reporting.

## Interface
- DIV_RESET, 8'd124: reset value of the clock divider. The SCLK half-period is (div+1) clk cycles.
- clk  in  1  system clock; every flop is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cs  in  1  peripheral select; a bus access happens in every cycle where cs=1.
- bus_addr  in  32  byte address; only [3:0] is decoded.
- bus_wr_val  in  32  write data.
- bus_bytesel  in  4  bytesel!=0 means write; bytesel==0 means read.
- bus_ack  out  1  registered copy of cs.
- bus_data  out  32  registered read data; 0 in any cycle without a valid read.
- spi_sclk  out  1  SPI clock; idles low.
- spi_mosi  out  1  master data out.
- spi_miso  in  1  slave data in; sampled only on the clk edge where SCLK rises.
- spi_cs_n  out  1  card select, driven directly from the control register.

## Operation
- Register map on bus_addr[3:0]:
  - 0x0 CTRL: RW. [7:0] div, [8] cs_n.
  - 0x4 STATUS: RO. [0] busy, [1] overrun.
  - 0x8 DATA: a write loads bus_wr_val[7:0] as the TX byte; a read returns {24'b0, rx_byte}.
  - Other offsets: reads return 0; writes are ignored.
- Register side effects:
  - CTRL writes take effect at any time.
  - div is copied into an internal div_q when a transfer starts; a CTRL write mid-transfer does not change the current byte.
  - A STATUS read clears overrun.
- FSM has three states: IDLE, LOW, HIGH. A 3-bit bit counter and an 8-bit half-period counter run underneath.
  - **IDLE**, on a DATA write: load tx_shift; spi_mosi ← bit7; bitcnt←0; halfcnt←0; div_q←div; go to LOW; busy=1.
  - **LOW** (spi_sclk=0): when halfcnt==div_q, set spi_sclk←1, shift spi_miso into rx_shift[0], halfcnt←0, go to HIGH. Otherwise halfcnt++.
  - **HIGH** (spi_sclk=1): when halfcnt==div_q, set spi_sclk←0.
    - If bitcnt==7: rx_byte←rx_shift, go to IDLE, busy←0.
    - Otherwise: bitcnt++, spi_mosi←next TX bit, go to LOW.
  - Otherwise halfcnt++.
- A DATA write while not IDLE is dropped and sets overrun (sticky).
- spi_mosi holds 1 in IDLE.

## Timing
- Reset values: bus_ack=0, bus_data=0, spi_sclk=0, spi_mosi=1, spi_cs_n=1, div=DIV_RESET, busy=0, overrun=0, rx_byte=8'h00, state=IDLE.
- Reset mid-transfer: the transfer aborts on that edge and every output takes its reset value on the same edge. No partial rx_byte update.
- Bus: bus_ack and bus_data are valid in the cycle after the cs cycle.
  - Every access is acked, including dropped writes and unmapped offsets.
  - Back-to-back accesses are allowed.
- Transfer latency: busy is cleared exactly 16*(div_q+1) cycles after the accepting edge. rx_byte is updated on that same edge.
- MISO is sampled 8 times, on the edges where spi_sclk goes 0→1. The first rising edge comes (div_q+1) cycles after acceptance.
- Simultaneous events:
  - A DATA write on the completion edge is dropped (state is still HIGH) and sets overrun.
  - A DATA read on the completion edge returns the old rx_byte.
  - A STATUS read on the same edge that overrun is set: set wins, and the returned value shows overrun=0.
- A CTRL cs_n write appears on spi_cs_n one cycle after the access.

## Test plan
- **Reset defaults:** assert rst mid-transfer. On the next edge: spi_sclk=0, spi_mosi=1, spi_cs_n=1, bus_data=0, bus_ack=0. STATUS read then returns 0 and CTRL reads 0x17C.
- **Loopback at div=0:** CTRL=0x000 (cs_n low), tie miso=mosi, write DATA 0xA5.
  - 8 SCLK pulses of 1 cycle high / 1 cycle low.
  - busy clears after 16 cycles.
  - DATA read returns 0x000000A5.
- **Slave pattern at div=3:** slave drives 0x3C on MISO, master writes 0xFF.
  - SCLK half-period is 4 cycles.
  - MOSI stays 1 throughout.
  - rx_byte=0x3C after 64 cycles.
- **Overrun:** write DATA during busy, then read STATUS.
  - Returns 0x3; a second read returns 0x1 (or 0x0 after completion).
  - The in-flight byte is unaffected.
- **Divider change mid-transfer:** at div=1 start a transfer, then write CTRL div=7. The current byte keeps 2-cycle half-periods; the next byte uses 8.
- **Bus decode:** read offset 0xC gives 0 with ack. A write to 0xC changes no register. bus_data returns to 0 in the cycle after every read.
